// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
// Holds the FSM state enum and the default parameter constants.
package fifo_arb_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int N_REQ      = 4;
  localparam int MAX_BURST  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports: i_req (request vector), i_last (last owner index),
//        o_pick (one-hot winner), o_idx (winner index).
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_pick,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_j;
  logic          w_found;

  // Walk from last+1 with wrap; the first set request wins.
  always_comb begin
    o_pick  = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = i_last;
    for (int k = 0; k < N; k++) begin
      w_j = (w_j == IW'(N - 1)) ? '0 : w_j + 1'b1;
      if (!w_found && i_req[w_j]) begin
        w_found     = 1'b1;
        o_pick[w_j] = 1'b1;
        o_idx       = w_j;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter feeding an async FIFO.
// Ports: wclk/wrst_n, arb_enable, req_valid/req_data/req_ready,
//        fifo_full, write_enable, data_in, grant.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_arb_pkg::DATA_WIDTH,
  parameter int N_REQ      = fifo_arb_pkg::N_REQ,
  parameter int MAX_BURST  = fifo_arb_pkg::MAX_BURST
) (
  input  logic                        wclk,
  input  logic                        wrst_n,
  input  logic                        arb_enable,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        fifo_full,
  output logic                        write_enable,
  output logic [DATA_WIDTH-1:0]       data_in,
  output logic [N_REQ-1:0]            grant
);

  localparam int CW = $clog2(MAX_BURST);
  localparam int IW = $clog2(N_REQ);

  arb_state_e            r_state;
  arb_state_e            w_next;
  logic [N_REQ-1:0]      r_grant;
  logic [CW-1:0]         r_count;
  logic [IW-1:0]         r_gidx;
  logic [IW-1:0]         r_last;
  logic [N_REQ-1:0]      w_pick;
  logic [IW-1:0]         w_pidx;
  logic                  w_vg;
  logic                  w_we;
  logic                  w_last_wr;
  logic                  w_start;
  logic                  w_exit;
  logic [DATA_WIDTH-1:0] w_data;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .i_req  (req_valid),
    .i_last (r_last),
    .o_pick (w_pick),
    .o_idx  (w_pidx)
  );

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_count <= '0;
      r_gidx  <= '0;
      r_last  <= IW'(N_REQ - 1);
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_grant <= w_pick;
        r_gidx  <= w_pidx;
      end else if (w_exit) begin
        r_grant <= '0;
        r_count <= '0;
        r_last  <= r_gidx;
      end else if (w_we) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  always_comb begin
    w_vg      = |(req_valid & r_grant);
    w_last_wr = w_we && (r_count == CW'(MAX_BURST - 1));
    w_start   = (r_state == IDLE) && arb_enable
                && (|req_valid);
    w_exit    = (r_state == BURST)
                && (!w_vg || w_last_wr);
    w_next    = r_state;
    unique case (r_state)
      IDLE:    w_next = w_start ? BURST : IDLE;
      BURST:   w_next = w_exit ? IDLE : BURST;
      default: w_next = IDLE;
    endcase
  end

  // Reset gates the strobe so an aborted burst
  // writes nothing while reset is held.
  always_comb begin
    w_we = wrst_n && (r_state == BURST)
           && w_vg && !fifo_full;
    w_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) begin
        w_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (!wrst_n || r_state != BURST) begin
      w_data = '0;
    end
  end

  assign write_enable = w_we;
  assign req_ready    = r_grant & {N_REQ{w_we}};
  assign data_in      = w_data;
  assign grant        = r_grant;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter.
// Directed scenarios followed by a randomized phase vs a model.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int MB = 16;

  logic            wclk = 1'b0;
  logic            wrst_n;
  logic            arb_enable;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            write_enable;
  logic [DW-1:0]   data_in;
  logic [N-1:0]    grant;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .N_REQ      (N),
    .MAX_BURST  (MB)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .arb_enable   (arb_enable),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .write_enable (write_enable),
    .data_in      (data_in),
    .grant        (grant)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: current owner (-1 idle), words written, last owner.
  int owner = -1;
  int wcnt  = 0;
  int last  = N - 1;
  bit known = 0;
  int seq[N];

  logic [DW-1:0]  wlog[$];
  bit             welog[$];
  logic [N-1:0]   glog[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic clr();
    wlog.delete();
    welog.delete();
    glog.delete();
  endtask

  task automatic cyc();
    logic [N-1:0]  eg;
    logic [N-1:0]  er;
    logic          ew;
    logic [DW-1:0] ed;
    bit            ov;
    for (int i = 0; i < N; i++)
      req_data[i*DW +: DW] = DW'((i << 6) | (seq[i] & 63));
    #1;
    ov = (owner >= 0) && (((req_valid >> owner) & 1) != 0);
    eg = (owner >= 0) ? (N'(1) << owner) : '0;
    ew = wrst_n && ov && !fifo_full;
    ed = (wrst_n && owner >= 0)
         ? DW'(req_data >> (owner * DW)) : '0;
    er = ew ? eg : '0;
    if (known) begin
      chk("grant", grant, eg);
      chk("write_enable", write_enable, ew);
      chk("req_ready", req_ready, er);
      chk("data_in", data_in, ed);
    end
    welog.push_back(write_enable === 1'b1);
    glog.push_back(grant);
    if (write_enable === 1'b1) wlog.push_back(data_in);
    if (ew) seq[owner]++;
    @(posedge wclk);
    if (!wrst_n) begin
      owner = -1;
      wcnt  = 0;
      last  = N - 1;
      known = 1;
    end else if (owner < 0) begin
      if (arb_enable && req_valid != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (owner < 0 &&
              ((req_valid >> ((last + k) % N)) & 1) != 0)
            owner = (last + k) % N;
        end
        wcnt = 0;
      end
    end else if (!ov) begin
      last  = owner;
      owner = -1;
      wcnt  = 0;
    end else if (!fifo_full) begin
      wcnt++;
      if (wcnt == MB) begin
        last  = owner;
        owner = -1;
        wcnt  = 0;
      end
    end
    @(negedge wclk);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    int nw;
    wrst_n     = 1'b0;
    arb_enable = 1'b1;
    req_valid  = '0;
    fifo_full  = 1'b0;
    req_data   = '0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    @(negedge wclk);

    // Reset and idle
    run(5);
    wrst_n = 1'b1;
    run(3);
    chk("idle_grant", grant, 0);
    chk("idle_we", write_enable, 0);
    chk("idle_data", data_in, 0);

    // Single long burst from requester 0
    clr();
    seq[0] = 0;
    req_valid = 4'b0001;
    run(34);
    req_valid = '0;
    cyc();
    chk("long_nwr", wlog.size(), 32);
    if (wlog.size() == 32) begin
      chk("long_w0", wlog[0], 8'h00);
      chk("long_w15", wlog[15], 8'h0F);
      chk("long_w16", wlog[16], 8'h10);
      chk("long_w31", wlog[31], 8'h1F);
    end
    chk("long_gap", welog[17], 0);
    chk("long_first", welog[1], 1);

    // Round-robin with all requesters valid
    wrst_n = 1'b0;
    run(2);
    wrst_n = 1'b1;
    clr();
    req_valid = 4'b1111;
    run(85);
    req_valid = '0;
    cyc();
    chk("rr_nwr", wlog.size(), 80);
    for (int k = 0; k < 5; k++)
      chk($sformatf("rr_g%0d", k), glog[17*k+1],
          64'(1 << (k % 4)));

    // FIFO-full stall in mid-burst
    wrst_n = 1'b0;
    run(2);
    wrst_n = 1'b1;
    clr();
    seq[0] = 0;
    req_valid = 4'b0001;
    run(6);
    fifo_full = 1'b1;
    run(7);
    fifo_full = 1'b0;
    run(11);
    req_valid = '0;
    cyc();
    nw = 0;
    for (int c = 6; c < 13; c++) nw += int'(welog[c]);
    chk("stall_nowr", nw, 0);
    chk("stall_grant", glog[12], 4'b0001);
    chk("stall_resume", welog[13], 1);
    chk("stall_nwr", wlog.size(), 16);
    if (wlog.size() == 16) chk("stall_w5", wlog[5], 8'h05);

    // Short burst by requester 2, then requester 3
    clr();
    req_valid = 4'b0100;
    run(4);
    chk("short_nwr", wlog.size(), 3);
    req_valid = 4'b1000;
    cyc();
    chk("short_exit", grant, 0);
    cyc();
    chk("short_next", grant, 4'b1000);
    run(3);
    req_valid = '0;
    run(2);

    // Reset in the middle of a burst
    wrst_n = 1'b0;
    run(2);
    wrst_n = 1'b1;
    req_valid = 4'b0001;
    run(9);
    wrst_n = 1'b0;
    req_valid = 4'b1111;
    cyc();
    chk("mrst_grant", grant, 0);
    chk("mrst_we", write_enable, 0);
    wrst_n = 1'b1;
    cyc();
    chk("mrst_prio", grant, 4'b0001);
    req_valid = '0;
    run(2);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      req_valid  = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0)
        req_valid = 4'b1111;
      fifo_full  = ($urandom_range(0, 9) < 3);
      arb_enable = ($urandom_range(0, 9) < 8);
      wrst_n     = ($urandom_range(0, 99) != 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
